// File: rtl/pipe_stage_chain_if.sv
// Fetch-side request (valid/pc/data, ready back) and write-back-side slot view.
interface pipe_stage_chain_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
);
  logic              in_valid;
  logic [PC_W-1:0]   in_pc;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [PC_W-1:0]   out_pc;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_pc, in_data,
    input  in_ready, out_valid, out_pc, out_data
  );

  modport slave (
    input  in_valid, in_pc, in_data,
    output in_ready, out_valid, out_pc, out_data
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// Generalised PC/payload pipeline register chain with per-slot freeze, bubbles, ranged flush, perf counters.
// Latency STAGES-1 edges to out_*; in_ready = ~hold[0] stalls the fetch side while any slot at or above 0 is frozen.
module pipe_stage_chain #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  pipe_stage_chain_if.slave            bus,
  input  logic [STAGES-1:0]            freeze,
  input  logic                         flush,
  input  logic [$clog2(STAGES)-1:0]    flush_stage,
  output logic [$clog2(STAGES+1)-1:0]  occupancy,
  output logic [CNT_W-1:0]             retire_cnt,
  output logic [CNT_W-1:0]             bubble_cnt,
  input  logic                         clr_cnt
);
  localparam int FS_W  = $clog2(STAGES);
  localparam int OCC_W = $clog2(STAGES+1);
  localparam logic [FS_W-1:0] FS_MAX = FS_W'(STAGES-2);

  logic [STAGES-1:0] vld_q, vld_d, hold, kill;
  logic [PC_W-1:0]   pc_q  [STAGES];
  logic [PC_W-1:0]   pc_d  [STAGES];
  logic [DATA_W-1:0] dat_q [STAGES];
  logic [DATA_W-1:0] dat_d [STAGES];
  logic [FS_W-1:0]   fs_clamp;
  logic [OCC_W-1:0]  occ_d;
  logic              retire, bubble;

  // A freeze on any older slot also holds every younger slot.
  always_comb begin
    fs_clamp = (flush_stage > FS_MAX) ? FS_MAX : flush_stage;
    for (int i = 0; i < STAGES; i++) begin
      hold[i] = |(freeze >> i);
      kill[i] = flush && (FS_W'(i) <= fs_clamp);
    end
  end

  always_comb begin
    vld_d[0] = vld_q[0];
    pc_d[0]  = pc_q[0];
    dat_d[0] = dat_q[0];
    if (kill[0]) begin
      vld_d[0] = 1'b0;
    end else if (!hold[0]) begin
      vld_d[0] = bus.in_valid;
      pc_d[0]  = bus.in_pc;
      dat_d[0] = bus.in_data;
    end
    for (int i = 1; i < STAGES; i++) begin
      vld_d[i] = vld_q[i];
      pc_d[i]  = pc_q[i];
      dat_d[i] = dat_q[i];
      if (kill[i]) begin
        vld_d[i] = 1'b0;
      end else if (!hold[i]) begin
        // Boundary between a held and a moving slot: inject a bubble, keep stale pc/data.
        if (hold[i-1]) begin
          vld_d[i] = 1'b0;
        end else begin
          vld_d[i] = vld_q[i-1];
          pc_d[i]  = pc_q[i-1];
          dat_d[i] = dat_q[i-1];
        end
      end
    end
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_d = occ_d + OCC_W'(vld_d[i]);
    end
    retire = vld_q[STAGES-1] && !hold[STAGES-1];
    bubble = !hold[STAGES-1] && !vld_d[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      occupancy <= '0;
      for (int i = 0; i < STAGES; i++) begin
        pc_q[i]  <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q     <= vld_d;
      occupancy <= occ_d;
      for (int i = 0; i < STAGES; i++) begin
        pc_q[i]  <= pc_d[i];
        dat_q[i] <= dat_d[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
      bubble_cnt <= '0;
    end else if (clr_cnt) begin
      retire_cnt <= '0;
      bubble_cnt <= '0;
    end else begin
      if (retire && (retire_cnt != '1)) retire_cnt <= retire_cnt + CNT_W'(1);
      if (bubble && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = ~hold[0];
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.out_pc    = pc_q[STAGES-1];
  assign bus.out_data  = dat_q[STAGES-1];
endmodule

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised chain of pipeline stage registers that carries a PC and a payload word (instruction or decoded bundle) with a per-register valid bit. It supports per-stage freeze with upstream back-pressure, bubble insertion, a ranged branch flush, and saturating retire/bubble counters. It sits between the fetch stage and write-back and replaces the separate fixed-width inter-stage registers with one generalised chain.

## Interface

**Parameters**
- DATA_W, 32: payload width.
- PC_W, 32: PC width.
- STAGES, 4: number of register slots; slot 0 is youngest (fetch side), slot STAGES-1 is oldest (write-back side). Legal range 2..16.
- CNT_W, 16: width of the performance counters.

**Ports**
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  the fetch side presents an instruction.
- in_pc  in  PC_W  PC of the presented instruction.
- in_data  in  DATA_W  payload of the presented instruction.
- in_ready  out  1  slot 0 will load this cycle; combinational, equals ~hold[0].
- freeze  in  STAGES  per-slot hold request; freeze[i] holds slot i.
- flush  in  1  branch flush request.
- flush_stage  in  $clog2(STAGES)  oldest slot to flush; slots 0..flush_stage are cleared.
- out_valid  out  1  valid bit of slot STAGES-1.
- out_pc  out  PC_W  PC of slot STAGES-1.
- out_data  out  DATA_W  payload of slot STAGES-1.
- occupancy  out  $clog2(STAGES+1)  count of valid slots; registered.
- retire_cnt  out  CNT_W  instructions that left slot STAGES-1; saturating.
- bubble_cnt  out  CNT_W  cycles in which slot STAGES-1 loaded a bubble; saturating.
- clr_cnt  in  1  synchronous clear of both counters.

## Operation

**Hold**
- hold[i] = OR of freeze[k] for k = i..STAGES-1.
- A held slot keeps its valid, pc and data.

**Advance**
- When hold[i] = 0, slot i loads the contents of slot i-1.
- Slot 0 loads {in_valid, in_pc, in_data}.
- Bubble rule: if hold[i-1] = 1 and hold[i] = 0, slot i loads valid = 0. Its pc and data are don't-care and are implemented as held.

**Flush**
- flush_stage is clamped to STAGES-2; the oldest slot is never flushed.
- When flush = 1, slots 0..flush_stage load valid = 0 on the next edge.
- The incoming in_valid is discarded on that edge.
- Flush overrides hold for the flushed slots.
- Slots above flush_stage advance or hold normally.

**Retire**
- A retire is an edge where out_valid = 1 and hold[STAGES-1] = 0.
- On each retire, retire_cnt increments.

**Bubble count**
- bubble_cnt increments on each edge where slot STAGES-1 is not held and its source (slot STAGES-2) is invalid or bubbled.

**Counters**
- Both counters saturate at 2^CNT_W-1.
- clr_cnt has priority over increment; the cleared value is 0 after the edge.

**Occupancy**
- Registered popcount of the next-state valid bits; it always matches the slot valids after each edge.

## Timing

- **Reset:** every valid = 0, every pc/data = 0, occupancy = 0, retire_cnt = 0, bubble_cnt = 0. out_valid, out_pc and out_data read 0 while rst is high. in_ready follows ~hold[0] even during reset.
- **Latency:** with no holds, an instruction accepted on edge N appears on out_* after edge N+STAGES-1, and retires on edge N+STAGES.
- **Throughput:** one instruction per cycle with no holds.
- **Handshake:** an instruction is accepted only on an edge with in_valid & in_ready & ~flush. The source holds in_pc/in_data while in_ready = 0.
- **Flush and freeze together:** flush in the same cycle as any freeze still clears slots 0..flush_stage. Held slots above flush_stage keep their contents.
- **Reset mid-operation:** asynchronous; all state clears immediately and no partial retire is counted.

## Test plan

- **Streaming (STAGES=4):** PCs 0,4,8,... every cycle, no freeze. Required: out_pc=0 visible after 3 edges, then consecutive PCs; retire_cnt=10 after 10 retires; occupancy=4 steady.
- **Freeze:** freeze[1]=1 for 2 cycles mid-stream. Required: in_ready=0 for 2 cycles; slots 0-1 hold; slot 2 loads 2 bubbles; bubble_cnt increments by 2 once those bubbles reach slot 3; no PC lost or duplicated at out_pc.
- **Flush:** flush=1 with flush_stage=1 while slots hold PCs 12,8,4,0. Required: after the edge, slots 0-1 invalid, in_pc 16 discarded, out_pc=4 next cycle, occupancy=2.
- **Flush versus hold:** flush with flush_stage=3 on STAGES=4 (clamped to 2) and freeze[3]=1 in the same cycle. Required: slots 0-2 invalid, slot 3 held, retire_cnt unchanged.
- **Counter saturation:** CNT_W=4, stream 20 instructions. Required: retire_cnt stops at 15. Then clr_cnt=1 concurrent with a retire gives retire_cnt=0.
- **Asynchronous reset:** assert rst between edges with a full pipe. Required: out_valid=0 and occupancy=0 immediately; after release, first output is 3 edges after the first accept.
